// File: rtl/two_port_mem_pipe.sv
// Two-port (1W+1R) memory with lane-masked writes, 1- or 2-cycle registered reads,
// optional same-address write-to-read forwarding and a zeroing sweep after reset.
module two_port_mem_pipe #(
  parameter int unsigned addresses    = 32,
  parameter int unsigned width        = 8,
  parameter int unsigned writeMask    = 1,
  parameter int unsigned readLatency  = 1,
  parameter bit          bypass       = 1'b1,
  parameter bit          clearOnReset = 1'b1,
  localparam int unsigned addressWidth = (addresses > 1) ? $clog2(addresses) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [addressWidth-1:0] writeAddress,
  input  logic [writeMask-1:0]    writeEnable,
  input  logic [width-1:0]        writeData,
  input  logic [addressWidth-1:0] readAddress,
  input  logic                    readEnable,
  output logic [width-1:0]        readData,
  output logic                    readValid,
  output logic                    busy
);

  localparam int unsigned LaneWidth = (writeMask == 0) ? width : width / writeMask;

  // Reject configurations the datapath cannot represent.
  if (addresses == 0 || width == 0 || writeMask == 0 || (width % writeMask) != 0 ||
      (readLatency != 1 && readLatency != 2)) begin : g_bad_params
    $error("FAIL!! two_port_mem_pipe: illegal parameters");
  end

  typedef enum logic {StClear, StReady} state_e;

  state_e                  state_q, state_d;
  logic [addressWidth-1:0] clr_cnt_q, clr_cnt_d;
  logic                    clr_last;
  logic                    ready;
  logic                    wr_in_range, rd_in_range;
  logic                    rd_fire;
  logic [width-1:0]        rd_word;
  logic                    out_valid;
  logic [width-1:0]        out_data;

  logic [width-1:0] mem [addresses];

  assign clr_last    = (32'(clr_cnt_q) == addresses - 1);
  assign ready       = (state_q == StReady);
  assign busy        = (state_q == StClear);
  // Non-power-of-two depths leave a hole in the address space.
  assign wr_in_range = (32'(writeAddress) < addresses);
  assign rd_in_range = (32'(readAddress) < addresses);
  assign rd_fire     = ready && readEnable;

  // Next-state logic for the clear sweep.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        if (clr_last) begin
          state_d   = StReady;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + addressWidth'(1);
        end
      end
      StReady: ;
      default: state_d = StReady;
    endcase
  end

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= clearOnReset ? StClear : StReady;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Array update: zeroing sweep while clearing, lane-masked writes once ready.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_in_range) begin
      for (int i = 0; i < int'(writeMask); i++) begin
        if (writeEnable[i]) begin
          mem[writeAddress][i*LaneWidth +: LaneWidth] <= writeData[i*LaneWidth +: LaneWidth];
        end
      end
    end
  end

  // Word returned by a read this cycle, including forwarded write lanes.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[readAddress];
      if (bypass && wr_in_range && (readAddress == writeAddress)) begin
        for (int i = 0; i < int'(writeMask); i++) begin
          if (writeEnable[i]) begin
            rd_word[i*LaneWidth +: LaneWidth] = writeData[i*LaneWidth +: LaneWidth];
          end
        end
      end
    end
  end

  if (readLatency == 2) begin : g_lat2
    logic             s1_valid_q;
    logic [width-1:0] s1_data_q;

    // Extra stage: holds the sampled word for one more edge.
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= rd_fire;
        if (rd_fire) begin
          s1_data_q <= rd_word;
        end
      end
    end

    assign out_valid = s1_valid_q;
    assign out_data  = s1_data_q;
  end else begin : g_lat1
    assign out_valid = rd_fire;
    assign out_data  = rd_word;
  end

  // Output register: data holds between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      readData  <= '0;
      readValid <= 1'b0;
    end else begin
      readValid <= out_valid;
      if (out_valid) begin
        readData <= out_data;
      end
    end
  end

endmodule

// File: tb/tb_two_port_mem_pipe.sv
// Randomised and directed bench for two_port_mem_pipe against a behavioural model.
// Instance A: 20 words x 32 bits, 4 lanes, latency 1, forwarding on.
// Instance B: 32 words x 8 bits, 1 lane, latency 2, forwarding off.
module tb_two_port_mem_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  wa0, ra0;
  logic [3:0]  we0;
  logic [31:0] wd0, rd0;
  logic        re0, rv0, busy0;
  logic [4:0]  wa1, ra1;
  logic [0:0]  we1;
  logic [7:0]  wd1, rd1;
  logic        re1, rv1, busy1;

  two_port_mem_pipe #(
    .addresses(20), .width(32), .writeMask(4), .readLatency(1), .bypass(1'b1), .clearOnReset(1'b1)
  ) u_dut_a (
    .clk(clk), .reset(reset), .writeAddress(wa0), .writeEnable(we0), .writeData(wd0),
    .readAddress(ra0), .readEnable(re0), .readData(rd0), .readValid(rv0), .busy(busy0)
  );

  two_port_mem_pipe #(
    .addresses(32), .width(8), .writeMask(1), .readLatency(2), .bypass(1'b0), .clearOnReset(1'b1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .writeAddress(wa1), .writeEnable(we1), .writeData(wd1),
    .readAddress(ra1), .readEnable(re1), .readData(rd1), .readValid(rv1), .busy(busy1)
  );

  // Reference model state, one slot per instance (both use 8-bit lanes).
  int unsigned m_addrs [2] = '{20, 32};
  int unsigned m_lanes [2] = '{4, 1};
  int unsigned m_lat   [2] = '{1, 2};
  bit          m_byp   [2] = '{1'b1, 1'b0};
  logic [31:0] mdl_mem [2][32];
  int          busy_left [2];
  bit          exp_v [2];
  logic [31:0] exp_d [2];
  bit          pend_v [2];
  logic [31:0] pend_d [2];
  int          valid_cnt [2];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Effect of one rising edge on the model for instance d.
  task automatic model_edge(input int d, input logic [4:0] wa, input logic [3:0] we,
                            input logic [31:0] wd, input logic [4:0] ra, input logic re);
    bit          rv;
    logic [31:0] r;
    bit          ov;
    logic [31:0] od;
    if (reset) begin
      busy_left[d] = int'(m_addrs[d]);
      exp_v[d]     = 1'b0;
      exp_d[d]     = '0;
      pend_v[d]    = 1'b0;
      pend_d[d]    = '0;
      return;
    end
    rv = 1'b0;
    r  = '0;
    if (busy_left[d] > 0) begin
      mdl_mem[d][int'(m_addrs[d]) - busy_left[d]] = '0;
      busy_left[d]--;
    end else begin
      if (re) begin
        rv = 1'b1;
        if (ra < m_addrs[d]) begin
          r = mdl_mem[d][ra];
          if (m_byp[d] && ra == wa) begin
            for (int i = 0; i < int'(m_lanes[d]); i++) if (we[i]) r[i*8 +: 8] = wd[i*8 +: 8];
          end
        end
      end
      if (wa < m_addrs[d]) begin
        for (int i = 0; i < int'(m_lanes[d]); i++) if (we[i]) mdl_mem[d][wa][i*8 +: 8] = wd[i*8 +: 8];
      end
    end
    if (m_lat[d] == 1) begin
      ov = rv;
      od = r;
    end else begin
      ov        = pend_v[d];
      od        = pend_d[d];
      pend_v[d] = rv;
      pend_d[d] = r;
    end
    exp_v[d] = ov;
    if (ov) exp_d[d] = od;
  endtask

  // Advance one clock and compare every output of both instances with the model.
  task automatic step();
    model_edge(0, wa0, we0, wd0, ra0, re0);
    model_edge(1, wa1, {3'b000, we1}, {24'h0, wd1}, ra1, re1);
    @(posedge clk);
    #1;
    check_val("busy_a", 32'(busy0), 32'(busy_left[0] > 0));
    check_val("busy_b", 32'(busy1), 32'(busy_left[1] > 0));
    check_val("valid_a", 32'(rv0), 32'(exp_v[0]));
    check_val("valid_b", 32'(rv1), 32'(exp_v[1]));
    check_val("data_a", rd0, exp_d[0]);
    check_val("data_b", 32'(rd1), exp_d[1]);
    if (rv0) valid_cnt[0]++;
    if (rv1) valid_cnt[1]++;
  endtask

  task automatic idle();
    wa0 = '0; we0 = '0; wd0 = '0; ra0 = '0; re0 = 1'b0;
    wa1 = '0; we1 = '0; wd1 = '0; ra1 = '0; re1 = 1'b0;
  endtask

  task automatic rand_in();
    wa0 = 5'($urandom_range(0, 31));
    we0 = 4'($urandom);
    wd0 = $urandom;
    ra0 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
    re0 = 1'($urandom);
    wa1 = 5'($urandom_range(0, 31));
    we1 = 1'($urandom);
    wd1 = 8'($urandom);
    ra1 = ($urandom_range(0, 3) == 0) ? wa1 : 5'($urandom_range(0, 31));
    re1 = 1'($urandom);
  endtask

  // Counts the cycles B stays busy (bounded); A's busy cycles are counted alongside.
  task automatic count_sweep(output int nb, output int na, input bit random_io);
    nb = 0;
    na = 0;
    while (busy1 && nb < 100) begin
      if (random_io) rand_in(); else idle();
      if (busy0) na++;
      else begin
        we0 = '0;
        re0 = 1'b0;
      end
      step();
      nb++;
    end
  endtask

  initial begin
    int nb, na;
    logic [7:0] b_vals [3];
    b_vals = '{8'h11, 8'h22, 8'h33};
    valid_cnt = '{0, 0};

    // Reset and initial sweep; requests during the sweep must be ignored.
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_sweep(nb, na, 1'b1);
    check_val("sweep_len_b", 32'(nb), 32'd32);
    check_val("sweep_len_a", 32'(na), 32'd20);

    // Every address reads back zero, one strobe per read.
    idle();
    valid_cnt = '{0, 0};
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a);
      re1 = 1'b1;
      ra0 = 5'(a);
      re0 = (a < 20);
      step();
    end
    idle();
    step();
    step();
    check_val("read_all_cnt_b", 32'(valid_cnt[1]), 32'd32);
    check_val("read_all_cnt_a", 32'(valid_cnt[0]), 32'd20);

    // Lane-masked overwrite.
    wa0 = 5'd3; we0 = 4'hF; wd0 = 32'hAABBCCDD;
    step();
    we0 = 4'b0101; wd0 = 32'h11223344;
    step();
    idle();
    ra0 = 5'd3; re0 = 1'b1;
    step();
    check_val("lane_mask", rd0, 32'hAA22CC44);
    idle();

    // Latency-2 back-to-back reads.
    for (int k = 0; k < 3; k++) begin
      wa1 = 5'(k + 1); we1 = 1'b1; wd1 = b_vals[k];
      step();
    end
    idle();
    ra1 = 5'd1; re1 = 1'b1;
    step();
    check_val("lat2_first_edge", 32'(rv1), 32'd0);
    ra1 = 5'd2;
    step();
    check_val("lat2_v1", 32'(rv1), 32'd1);
    check_val("lat2_d1", 32'(rd1), 32'h11);
    ra1 = 5'd3;
    step();
    check_val("lat2_d2", 32'(rd1), 32'h22);
    re1 = 1'b0;
    step();
    check_val("lat2_v3", 32'(rv1), 32'd1);
    check_val("lat2_d3", 32'(rd1), 32'h33);
    step();
    check_val("lat2_done", 32'(rv1), 32'd0);
    check_val("lat2_hold", 32'(rd1), 32'h33);

    // Same-address collision: forwarded on A, pre-write data on B.
    wa0 = 5'd5; we0 = 4'hF; wd0 = 32'h000000FF; ra0 = 5'd5; re0 = 1'b1;
    wa1 = 5'd5; we1 = 1'b1; wd1 = 8'hFF;        ra1 = 5'd5; re1 = 1'b1;
    step();
    check_val("coll_bypass", rd0, 32'h000000FF);
    idle();
    step();
    check_val("coll_nobypass_v", 32'(rv1), 32'd1);
    check_val("coll_nobypass", 32'(rd1), 32'h00);
    ra0 = 5'd5; re0 = 1'b1; ra1 = 5'd5; re1 = 1'b1;
    step();
    check_val("coll_after_a", rd0, 32'h000000FF);
    idle();
    step();
    check_val("coll_after_b", 32'(rd1), 32'hFF);

    // Out-of-range access on the 20-word instance.
    wa0 = 5'd4;  we0 = 4'hF; wd0 = 32'h44;
    step();
    wa0 = 5'd9;  wd0 = 32'h99;
    step();
    wa0 = 5'd25; wd0 = 32'h5A;
    step();
    idle();
    ra0 = 5'd4; re0 = 1'b1;
    step();
    check_val("oor_alias4", rd0, 32'h44);
    ra0 = 5'd25;
    step();
    check_val("oor_valid", 32'(rv0), 32'd1);
    check_val("oor_data", rd0, 32'h0);
    ra0 = 5'd9;
    step();
    check_val("oor_alias9", rd0, 32'h99);
    idle();

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      rand_in();
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    count_sweep(nb, na, 1'b1);

    // Reset at sweep count 10 restarts the full sweep.
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rand_in();
      step();
    end
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_sweep(nb, na, 1'b1);
    check_val("restart_len_b", 32'(nb), 32'd32);
    check_val("restart_len_a", 32'(na), 32'd20);

    // Reset with a latency-2 read in flight drops that read.
    idle();
    ra1 = 5'd7; re1 = 1'b1;
    step();
    idle();
    reset = 1'b1;
    step();
    check_val("flush_valid", 32'(rv1), 32'd0);
    reset = 1'b0;
    valid_cnt = '{0, 0};
    count_sweep(nb, na, 1'b0);
    check_val("flush_len_b", 32'(nb), 32'd32);
    check_val("flush_no_strobe", 32'(valid_cnt[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
